// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 9-bit core.
// Holds the program counter and drives it to a combinational instruction ROM.
// Forwards the fetched word to the decoder, or NOP_WORD outside RUN.
// Taken branches jump to an absolute address read from a writable target LUT.
// Done is sticky and is cleared only by Reset.
// There is no valid/ready handshake here. Stall is a plain level input that
// holds the PC for the cycle it is high. LutWrEn is a single-cycle write strobe.
module fetch_unit #(
  parameter int                   PC_W      = 10,
  parameter int                   INSTR_W   = 9,
  parameter int                   LUT_IDX_W = 4,
  parameter logic [INSTR_W-1:0]   HALT_WORD = 9'h0FF,
  parameter logic [INSTR_W-1:0]   NOP_WORD  = 9'h000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  BranchEn,
  input  logic                  Taken,
  input  logic [LUT_IDX_W-1:0]  TargetIdx,
  input  logic                  LutWrEn,
  input  logic [LUT_IDX_W-1:0]  LutWrIdx,
  input  logic [PC_W-1:0]       LutWrData,
  input  logic [INSTR_W-1:0]    InstrIn,
  output logic [PC_W-1:0]       ProgCtr,
  output logic [INSTR_W-1:0]    InstrOut,
  output logic                  Done,
  output logic [1:0]            StateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int LUT_DEPTH = 1 << LUT_IDX_W;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic              done, done_nxt;
  logic [PC_W-1:0]   lut [LUT_DEPTH];
  logic [PC_W-1:0]   branch_target;
  logic              is_halt_word;
  logic              at_rom_end;

  // Read the target before this edge's write lands, so a same-cycle write to
  // the same index is seen only from the next cycle onward.
  assign branch_target = lut[TargetIdx];
  assign is_halt_word  = (InstrIn == HALT_WORD);
  assign at_rom_end    = (pc == PC_MAX);

  // Target LUT is written in every state, Reset included, and never cleared.
  always_ff @(posedge Clk) begin
    if (LutWrEn) begin
      lut[LutWrIdx] <= LutWrData;
    end
  end

  // State, program counter and sticky Done register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and next-PC selection. Halt word outranks stall, stall outranks
  // branch, and sequential fetch at the last ROM address halts instead of wrapping.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    done_nxt  = done;
    unique case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (is_halt_word) begin
          done_nxt  = 1'b1;
          state_nxt = HALT;
        end else if (Stall) begin
          pc_nxt = pc;
        end else if (BranchEn && Taken) begin
          pc_nxt = branch_target;
        end else if (at_rom_end) begin
          done_nxt  = 1'b1;
          state_nxt = HALT;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Decoder sees the ROM word only while running; otherwise it sees a NOP.
  always_comb begin
    InstrOut = NOP_WORD;
    if (state == RUN) begin
      InstrOut = InstrIn;
    end
  end

  assign ProgCtr  = pc;
  assign Done     = done;
  assign StateDbg = state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural ROM.
// Each step drives the inputs and pushes the expected {PC, Done, InstrOut}.
// After the clock edge the step pops that entry and compares it with the DUT.
module tb_fetch_unit;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_IDX_W = 4;
  localparam logic [INSTR_W-1:0] HALT_W = 9'h0FF;
  localparam logic [INSTR_W-1:0] NOP_W  = 9'h000;
  localparam int EXP_W = PC_W + 1 + INSTR_W;

  logic                  Clk;
  logic                  Reset;
  logic                  Stall;
  logic                  BranchEn;
  logic                  Taken;
  logic [LUT_IDX_W-1:0]  TargetIdx;
  logic                  LutWrEn;
  logic [LUT_IDX_W-1:0]  LutWrIdx;
  logic [PC_W-1:0]       LutWrData;
  logic [INSTR_W-1:0]    InstrIn;
  logic [PC_W-1:0]       ProgCtr;
  logic [INSTR_W-1:0]    InstrOut;
  logic                  Done;
  logic [1:0]            StateDbg;

  logic [INSTR_W-1:0]    rom [1 << PC_W];
  logic [EXP_W-1:0]      exp_q [$];

  int vectors;
  int miscompares;

  // Clock and combinational ROM.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  assign InstrIn = rom[ProgCtr];

  fetch_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Stall     (Stall),
    .BranchEn  (BranchEn),
    .Taken     (Taken),
    .TargetIdx (TargetIdx),
    .LutWrEn   (LutWrEn),
    .LutWrIdx  (LutWrIdx),
    .LutWrData (LutWrData),
    .InstrIn   (InstrIn),
    .ProgCtr   (ProgCtr),
    .InstrOut  (InstrOut),
    .Done      (Done),
    .StateDbg  (StateDbg)
  );

  // Watchdog: stop a run that stalls instead of reaching the summary.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // One clock step. Push the expectation, advance one edge, then pop and compare.
  // With run=1 the decoder should see the ROM word at the expected PC.
  task automatic step(input logic [PC_W-1:0] pc, input logic done, input logic run);
    logic [INSTR_W-1:0] e_instr;
    logic [EXP_W-1:0]   e;
    e_instr = run ? rom[pc] : NOP_W;
    exp_q.push_back({pc, done, e_instr});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    vectors++;
    assert (ProgCtr === e[EXP_W-1 -: PC_W]) else begin
      miscompares++;
      $error("FAIL pc: observed %h expected %h", ProgCtr, e[EXP_W-1 -: PC_W]);
    end
    vectors++;
    assert (Done === e[INSTR_W]) else begin
      miscompares++;
      $error("FAIL done: observed %b expected %b (pc %h)", Done, e[INSTR_W], ProgCtr);
    end
    vectors++;
    assert (InstrOut === e[INSTR_W-1:0]) else begin
      miscompares++;
      $error("FAIL instr: observed %h expected %h (pc %h)", InstrOut, e[INSTR_W-1:0], ProgCtr);
    end
  endtask

  task automatic clear_ctl();
    Stall    = 1'b0;
    BranchEn = 1'b0;
    Taken    = 1'b0;
    TargetIdx = '0;
    LutWrEn  = 1'b0;
    LutWrIdx = '0;
    LutWrData = '0;
  endtask

  // Assert Reset for one edge, then release it for the IDLE->RUN edge.
  task automatic do_reset();
    Reset = 1'b1;
    step(10'h000, 1'b0, 1'b0);
    LutWrEn = 1'b0;
    Reset = 1'b0;
    step(10'h000, 1'b0, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = NOP_W;
    Reset = 1'b1;
    clear_ctl();

    // Straight line with a halt word at address 4.
    rom[4] = HALT_W;
    do_reset();
    for (int p = 1; p <= 4; p++) step(PC_W'(p), 1'b0, 1'b1);
    step(10'h004, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(10'h004, 1'b1, 1'b0);

    // Taken branch through LUT[3]. The entry is written during Reset.
    rom[4]     = NOP_W;
    rom[10'h020] = 9'h0AB;
    rom[10'h021] = HALT_W;
    rom[7]     = HALT_W;
    LutWrEn = 1'b1; LutWrIdx = 4'd3; LutWrData = 10'h020;
    do_reset();
    step(10'h001, 1'b0, 1'b1);
    step(10'h002, 1'b0, 1'b1);
    BranchEn = 1'b1; Taken = 1'b1; TargetIdx = 4'd3;
    step(10'h020, 1'b0, 1'b1);
    clear_ctl();
    step(10'h021, 1'b0, 1'b1);
    step(10'h021, 1'b1, 1'b0);

    // Branch to the last ROM address. A same-cycle write to that index must not
    // be used yet. The fetch after it halts instead of wrapping.
    LutWrEn = 1'b1; LutWrIdx = 4'd0; LutWrData = 10'h3FF;
    do_reset();
    BranchEn = 1'b1; Taken = 1'b1; TargetIdx = 4'd0;
    LutWrEn = 1'b1; LutWrIdx = 4'd0; LutWrData = 10'h010;
    step(10'h3FF, 1'b0, 1'b1);
    clear_ctl();
    step(10'h3FF, 1'b1, 1'b0);
    step(10'h3FF, 1'b1, 1'b0);
    do_reset();
    BranchEn = 1'b1; Taken = 1'b1; TargetIdx = 4'd0;
    step(10'h010, 1'b0, 1'b1);
    clear_ctl();
    step(10'h011, 1'b0, 1'b1);

    // Not-taken branch, and Taken with no branch. Stall during IDLE is ignored.
    Reset = 1'b1;
    step(10'h000, 1'b0, 1'b0);
    Reset = 1'b0; Stall = 1'b1; BranchEn = 1'b1; Taken = 1'b1; TargetIdx = 4'd3;
    step(10'h000, 1'b0, 1'b1);
    clear_ctl();
    step(10'h001, 1'b0, 1'b1);
    step(10'h002, 1'b0, 1'b1);
    BranchEn = 1'b1; Taken = 1'b0; TargetIdx = 4'd3;
    step(10'h003, 1'b0, 1'b1);
    BranchEn = 1'b0; Taken = 1'b1;
    step(10'h004, 1'b0, 1'b1);
    clear_ctl();
    step(10'h005, 1'b0, 1'b1);

    // Stall at PC 5 for three cycles.
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) step(10'h005, 1'b0, 1'b1);
    Stall = 1'b0;
    step(10'h006, 1'b0, 1'b1);
    step(10'h007, 1'b0, 1'b1);

    // Reset at PC 7 has priority over the halt word. The run then repeats.
    Reset = 1'b1;
    step(10'h000, 1'b0, 1'b0);
    Reset = 1'b0;
    step(10'h000, 1'b0, 1'b1);
    for (int p = 1; p <= 7; p++) step(PC_W'(p), 1'b0, 1'b1);

    // A stall on the halt word still raises Done.
    Stall = 1'b1;
    step(10'h007, 1'b1, 1'b0);
    Stall = 1'b0;
    for (int k = 0; k < 3; k++) step(10'h007, 1'b1, 1'b0);

    // Reset after Done clears everything, and the LUT entries survive it.
    Reset = 1'b1;
    step(10'h000, 1'b0, 1'b0);
    Reset = 1'b0;
    step(10'h000, 1'b0, 1'b1);
    step(10'h001, 1'b0, 1'b1);
    step(10'h002, 1'b0, 1'b1);
    BranchEn = 1'b1; Taken = 1'b1; TargetIdx = 4'd3;
    step(10'h020, 1'b0, 1'b1);
    TargetIdx = 4'd0;
    step(10'h010, 1'b0, 1'b1);
    clear_ctl();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
